// File: rtl/nav_button_conditioner.sv
// Purpose: synchronize, debounce and auto-repeat five board pushbuttons; free-running pacing tick.
// Latency: level/pulse rise DEBOUNCE_CYCLES+3 edges after raw first samples high; tick every TICK_DIV cycles.
// Backpressure: none; outputs are free-running registered levels and one-cycle pulses.
module nav_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 15_000_000,
    parameter int TICK_DIV        = 250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse,
    output logic       tick
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] PERIOD_LAST = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam bit            REPEAT_EN   = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        HELD   = 2'd2,
        DISARM = 2'd3
    } state_t;

    logic [4:0]    s1;
    logic [4:0]    s2;
    logic [TW-1:0] tcnt;

    // Two-flop synchronizer on all raw buttons; only s2 feeds the channel FSMs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    genvar i;
    for (i = 0; i < 5; i++) begin : g_ch
        state_t        state;
        logic [DW-1:0] dcnt;
        logic [RW-1:0] rcnt;
        logic          phase;
        logic          level_q;
        logic          pulse_q;

        // Debounce FSM plus auto-repeat; the repeat engine runs on every cycle spent in HELD,
        // and any (re)entry to HELD restarts the repeat delay from zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state   <= IDLE;
                dcnt    <= '0;
                rcnt    <= '0;
                phase   <= 1'b0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s2[i]) begin
                            state <= ARM;
                            dcnt  <= '0;
                        end
                    end
                    ARM: begin
                        if (!s2[i]) begin
                            state <= IDLE;
                        end else if (dcnt == DEB_LAST) begin
                            state   <= HELD;
                            level_q <= 1'b1;
                            pulse_q <= 1'b1;
                            rcnt    <= '0;
                            phase   <= 1'b0;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!s2[i]) begin
                            state <= DISARM;
                            dcnt  <= '0;
                        end
                        if (REPEAT_EN) begin
                            if (!phase && rcnt == DELAY_LAST) begin
                                pulse_q <= 1'b1;
                                rcnt    <= '0;
                                phase   <= 1'b1;
                            end else if (phase && rcnt == PERIOD_LAST) begin
                                pulse_q <= 1'b1;
                                rcnt    <= '0;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                    end
                    DISARM: begin
                        if (s2[i]) begin
                            // Release bounce: back to HELD silently, repeat delay restarts.
                            state <= HELD;
                            rcnt  <= '0;
                            phase <= 1'b0;
                        end else if (dcnt == DEB_LAST) begin
                            state   <= IDLE;
                            level_q <= 1'b0;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_q;
    end

    // Free-running divider; tick is registered high for the cycle after tcnt hits its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else if (tcnt == TICK_LAST) begin
            tcnt <= '0;
            tick <= 1'b1;
        end else begin
            tcnt <= tcnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nav_button_conditioner.sv
// Purpose: randomized plus directed bench for nav_button_conditioner with a scoreboard model.
// Latency: model predicts every cycle's outputs; monitor compares one cycle's worth per clock.
// Backpressure: none; the scoreboard queue holds one expected response per clock edge.
module tb_nav_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam int TD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] level;
        logic [4:0] pulse;
        logic       tick;
    } resp_t;

    resp_t exp_q[$];

    nav_button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .TICK_DIV       (TD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the synchronized input has disagreed with it for
    // D+1 consecutive samples; repeats are timed by the number of edges spent holding.
    logic [4:0] m_s1 = '0;
    logic [4:0] m_s2 = '0;
    logic [4:0] m_level = '0;
    int         m_mis[5];
    int         m_age[5];
    int         m_edges = 0;

    always @(posedge clk) begin
        resp_t      r;
        logic [4:0] s2_now;
        r = '0;
        if (rst) begin
            m_s1    = '0;
            m_s2    = '0;
            m_level = '0;
            m_edges = 0;
            for (int i = 0; i < 5; i++) begin
                m_mis[i] = 0;
                m_age[i] = 0;
            end
        end else begin
            s2_now = m_s2;
            m_s2   = m_s1;
            m_s1   = btn_raw;
            for (int i = 0; i < 5; i++) begin
                if (m_level[i] && m_mis[i] == 0 && RD != 0) begin
                    m_age[i]++;
                    if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0))
                        r.pulse[i] = 1'b1;
                end
                if (s2_now[i] != m_level[i]) begin
                    m_mis[i]++;
                    if (m_mis[i] == D + 1) begin
                        m_level[i] = ~m_level[i];
                        m_mis[i]   = 0;
                        if (m_level[i]) begin
                            r.pulse[i] = 1'b1;
                            m_age[i]   = 0;
                        end
                    end
                end else begin
                    if (m_level[i] && m_mis[i] > 0) m_age[i] = 0;
                    m_mis[i] = 0;
                end
            end
            m_edges++;
            r.tick = (m_edges % TD == 0);
        end
        r.level = m_level;
        exp_q.push_back(r);
    end

    // Monitor: pops the expected response for each edge and compares against the DUT.
    always @(posedge clk) begin
        resp_t a;
        resp_t e;
        #1;
        a = {btn_level, btn_pulse, tick};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty at %0t: actual level=%b pulse=%b tick=%b, no expected entry",
                     $time, a.level, a.pulse, a.tick);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_resp at %0t: actual level=%b pulse=%b tick=%b required level=%b pulse=%b tick=%b",
                         $time, a.level, a.pulse, a.tick, e.level, e.pulse, e.tick);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: run did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int dur[5];

        rst     = 1'b1;
        btn_raw = '0;
        cyc(3);

        // Clean press of bit 0 starting right at reset release.
        rst     = 1'b0;
        btn_raw = 5'b00001;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #2;
            if (e == 6)  chk("press_level_e6", 32'(btn_level), 32'h0);
            if (e == 7)  chk("press_pulse_e7", 32'(btn_pulse), 32'h1);
            if (e == 7)  chk("press_level_e7", 32'(btn_level), 32'h1);
            if (e == 8)  chk("pulse_gap_e8",   32'(btn_pulse), 32'h0);
            if (e == 17) chk("repeat_e17",     32'(btn_pulse), 32'h1);
            if (e == 22) chk("repeat_e22",     32'(btn_pulse), 32'h1);
            if (e == 7)  chk("tick_e7",        32'(tick),      32'h0);
            if (e == 8)  chk("tick_e8",        32'(tick),      32'h1);
            if (e == 16) chk("tick_e16",       32'(tick),      32'h1);
            if (e == 24) chk("tick_e24",       32'(tick),      32'h1);
        end
        @(negedge clk);
        btn_raw = '0;
        cyc(12);

        // Short high glitch on bit 2.
        btn_raw = 5'b00100;
        cyc(3);
        btn_raw = '0;
        cyc(10);

        // Bits 1 and 4 together.
        btn_raw = 5'b10010;
        cyc(25);
        btn_raw = '0;
        cyc(12);

        // Bit 3 held with a 2-cycle low glitch.
        btn_raw = 5'b01000;
        cyc(20);
        btn_raw = '0;
        cyc(2);
        btn_raw = 5'b01000;
        cyc(25);
        btn_raw = '0;
        cyc(12);

        // Reset while bit 0 is in HELD, button still held at release.
        btn_raw = 5'b00001;
        cyc(12);
        rst = 1'b1;
        #1;
        chk("rst_level", 32'(btn_level), 32'h0);
        chk("rst_pulse", 32'(btn_pulse), 32'h0);
        cyc(2);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #2;
            if (e == 7) chk("rerun_pulse_e7", 32'(btn_pulse), 32'h1);
        end
        @(negedge clk);
        btn_raw = '0;
        cyc(12);

        // Randomized bouncing on all buttons with occasional resets.
        for (int i = 0; i < 5; i++) dur[i] = $urandom_range(1, 30);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 799) == 0);
            for (int i = 0; i < 5; i++) begin
                if (dur[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
                end else begin
                    dur[i]--;
                end
            end
        end
        @(negedge clk);
        rst     = 1'b0;
        btn_raw = '0;
        cyc(20);
        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
